// File: rtl/ntt_masked_pwm_wb_ctrl.sv
// ntt_masked_pwm_wb_ctrl
// Writeback stage behind the masked pair-wise multiplier (pairwm). Each
// accepted coefficient pair is tracked through pairwm's fixed latency by a
// tag delay line. When the tag reaches the tap, the two arithmetic shares of
// res0/res1 are recombined and one registered memory write is issued.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   zeroize          synchronous clear of all state, drops in-flight pairs
//   in_valid/ready   pair handshake toward pairwm issue
//   in_accumulate    requested pairwm mode for the presented pair
//   in_addr, in_last destination address / final-pair tag
//   pwm_accumulate   registered mode driven to pairwm
//   res0, res1       {share1, share0} per coefficient, valid at the sample edge
//   wr_en/addr/data  registered write port, data = {coef1, coef0}
//   range_err        sticky: an unmasked coefficient was >= Q
//   busy             one or more pairs in flight
//   done             pulse alongside the write of the last-tagged pair
module ntt_masked_pwm_wb_ctrl #(
    parameter int MASKED_WIDTH = 24,
    parameter int COEFF_WIDTH  = 12,
    parameter int Q            = 3329,
    parameter int LAT_ACC      = 24,
    parameter int LAT_NOACC    = 23,
    parameter int ADDR_WIDTH   = 7
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      zeroize,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_accumulate,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic                      in_last,
    output logic                      pwm_accumulate,
    input  logic [2*MASKED_WIDTH-1:0] res0,
    input  logic [2*MASKED_WIDTH-1:0] res1,
    output logic                      wr_en,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [2*COEFF_WIDTH-1:0]  wr_data,
    output logic                      range_err,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_W = $clog2(LAT_ACC + 2);
    localparam logic [MASKED_WIDTH-1:0] Q_M = MASKED_WIDTH'(Q);

    logic [LAT_ACC-1:0]    dl_valid;
    logic [LAT_ACC-1:0]    dl_last;
    logic [ADDR_WIDTH-1:0] dl_addr [LAT_ACC];

    logic                  acc_mode;
    logic [CNT_W-1:0]      inflight;
    // Holds in_ready low while reset is asserted and for the first edge after.
    logic                  ready_en;

    logic                    accept;
    logic                    tap_valid;
    logic                    tap_last;
    logic [ADDR_WIDTH-1:0]   tap_addr;
    logic [MASKED_WIDTH-1:0] s0;
    logic [MASKED_WIDTH-1:0] s1;
    logic                    out_of_range;

    // A mode change may only be accepted once the pipeline is empty, so the
    // mode seen by pairwm never changes under an in-flight pair.
    always_comb begin
        in_ready = ready_en & ~zeroize &
                   ~((inflight != '0) & (in_accumulate != acc_mode));
        accept   = in_valid & in_ready;
    end

    always_comb begin
        tap_valid = '0;
        tap_last  = '0;
        tap_addr  = '0;
        if (acc_mode) begin
            tap_valid = dl_valid[LAT_ACC-1];
            tap_last  = dl_last[LAT_ACC-1];
            tap_addr  = dl_addr[LAT_ACC-1];
        end else begin
            tap_valid = dl_valid[LAT_NOACC-1];
            tap_last  = dl_last[LAT_NOACC-1];
            tap_addr  = dl_addr[LAT_NOACC-1];
        end
    end

    // Share recombination wraps mod 2^MASKED_WIDTH by construction.
    always_comb begin
        s0 = res0[MASKED_WIDTH-1:0] + res0[2*MASKED_WIDTH-1:MASKED_WIDTH];
        s1 = res1[MASKED_WIDTH-1:0] + res1[2*MASKED_WIDTH-1:MASKED_WIDTH];
        out_of_range = (s0 >= Q_M) | (s1 >= Q_M);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_valid <= '0;
            dl_last  <= '0;
            for (int unsigned i = 0; i < LAT_ACC; i++) begin
                dl_addr[i] <= '0;
            end
        end else if (zeroize) begin
            dl_valid <= '0;
            dl_last  <= '0;
            for (int unsigned i = 0; i < LAT_ACC; i++) begin
                dl_addr[i] <= '0;
            end
        end else begin
            dl_valid <= {dl_valid[LAT_ACC-2:0], accept};
            dl_last  <= {dl_last[LAT_ACC-2:0], in_last};
            dl_addr[0] <= in_addr;
            for (int unsigned i = 1; i < LAT_ACC; i++) begin
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
            acc_mode <= 1'b0;
        end else if (zeroize) begin
            inflight <= '0;
            acc_mode <= 1'b0;
        end else begin
            case ({accept, tap_valid})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
            // Uses the pre-edge count: a drain on this same edge does not
            // open the window for a mode change.
            if (accept && (inflight == '0)) begin
                acc_mode <= in_accumulate;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            range_err <= 1'b0;
        end else if (zeroize) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            wr_en <= tap_valid;
            done  <= tap_valid & tap_last;
            if (tap_valid) begin
                wr_addr <= tap_addr;
                wr_data <= {s1[COEFF_WIDTH-1:0], s0[COEFF_WIDTH-1:0]};
                if (out_of_range) begin
                    range_err <= 1'b1;
                end
            end
        end
    end

    assign pwm_accumulate = acc_mode;
    assign busy           = (inflight != '0);

endmodule

// File: tb/tb_ntt_masked_pwm_wb_ctrl.sv
// Scoreboard bench for ntt_masked_pwm_wb_ctrl. Stimulus pushes the expected
// write (address, data, last tag, cycle) for every accepted pair and schedules
// the pairwm share values for the cycle they must be valid; a monitor pops
// and compares whenever wr_en is seen.
module tb_ntt_masked_pwm_wb_ctrl;

    localparam int MW = 24;
    localparam int CW = 12;
    localparam int AW = 7;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            zeroize;
    logic            in_valid;
    logic            in_ready;
    logic            in_accumulate;
    logic [AW-1:0]   in_addr;
    logic            in_last;
    logic            pwm_accumulate;
    logic [2*MW-1:0] res0;
    logic [2*MW-1:0] res1;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [2*CW-1:0] wr_data;
    logic            range_err;
    logic            busy;
    logic            done;

    ntt_masked_pwm_wb_ctrl #(
        .MASKED_WIDTH(24),
        .COEFF_WIDTH (12),
        .Q           (3329),
        .LAT_ACC     (24),
        .LAT_NOACC   (23),
        .ADDR_WIDTH  (7)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .zeroize       (zeroize),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_accumulate (in_accumulate),
        .in_addr       (in_addr),
        .in_last       (in_last),
        .pwm_accumulate(pwm_accumulate),
        .res0          (res0),
        .res1          (res1),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .range_err     (range_err),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [2*CW-1:0] data;
        logic            last;
        int              wcyc;
    } exp_t;

    exp_t            q[$];
    exp_t            mon_e;
    logic [2*MW-1:0] r0_sched[int];
    logic [2*MW-1:0] r1_sched[int];
    int              total = 0;
    int              bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Share values only exist in the cycle before their sample edge; any other
    // cycle carries a pattern that unmasks to an out-of-range value.
    always @(negedge clk) begin
        if (r0_sched.exists(cyc)) begin
            res0 = r0_sched[cyc];
            res1 = r1_sched[cyc];
        end else begin
            res0 = 48'h5A5A5A_A5A5A5;
            res1 = 48'h5A5A5A_A5A5A5;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_en) begin
                if (q.size() == 0) begin
                    chk("unexpected_wr", wr_en, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("wr_addr", wr_addr, mon_e.addr);
                    chk("wr_data", wr_data, mon_e.data);
                    chk("done_tag", done, mon_e.last);
                    chk("wr_cycle", cyc, mon_e.wcyc);
                end
            end else if (done) begin
                chk("done_without_wr", done, 0);
            end
        end
    end

    // Called at a negedge; returns at a later negedge with in_valid low.
    task automatic issue(input logic acc, input logic [AW-1:0] a, input logic last,
                         input logic [MW-1:0] r0a, input logic [MW-1:0] r0b,
                         input logic [MW-1:0] r1a, input logic [MW-1:0] r1b,
                         input logic [2*CW-1:0] exp_data, output int stalls);
        int   lat;
        exp_t e;
        stalls        = 0;
        in_valid      = 1'b1;
        in_accumulate = acc;
        in_addr       = a;
        in_last       = last;
        #1;
        while (!in_ready && stalls < 100) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
        end else begin
            lat = acc ? 24 : 23;
            r0_sched[cyc + lat] = {r0b, r0a};
            r1_sched[cyc + lat] = {r1b, r1a};
            e.addr = a;
            e.data = exp_data;
            e.last = last;
            e.wcyc = cyc + lat + 1;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((q.size() != 0 || busy) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        chk(name, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            st;
        int            guard;
        logic [11:0]   c0;
        logic [11:0]   c1;
        logic [MW-1:0] va;
        logic [MW-1:0] vb;
        reset_n       = 1'b0;
        zeroize       = 1'b0;
        in_valid      = 1'b0;
        in_accumulate = 1'b0;
        in_addr       = '0;
        in_last       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {wr_en, wr_addr, wr_data, range_err, busy, done, in_ready, pwm_accumulate}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single pair, no accumulate: presented in cycle 10, written in cycle 34.
        while (cyc < 10) @(negedge clk);
        issue(0, 7'd5, 0, 24'h000100, 24'hFFFF00, 24'd3000, 24'd328, {12'd3328, 12'd0}, st);
        drain("single_drain");
        chk("single_range_err", range_err, 0);

        // 64 back-to-back accumulate pairs, last on address 63.
        for (int i = 0; i < 64; i++) begin
            va = MW'(i * 7);
            vb = MW'(i * 5);
            c0 = 12'(i * 12);
            c1 = 12'(i);
            issue(1, AW'(i), i == 63, va, vb, 24'hFFFFFF, MW'(i + 1), {c1, c0}, st);
            chk("b2b_no_stall", st, 0);
        end
        chk("b2b_busy", busy, 1);
        chk("b2b_pwm_acc", pwm_accumulate, 1);
        guard = 0;
        while (!done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("b2b_done_seen", done, 1);
        chk("b2b_done_addr", wr_addr, 63);
        @(negedge clk);
        chk("b2b_busy_after_done", busy, 0);
        drain("b2b_drain");

        // Mode switch: three non-accumulate pairs, then an accumulate pair.
        for (int i = 0; i < 3; i++) begin
            issue(0, AW'(100 + i), 0, 24'd10, 24'd20, 24'hFFFFF0, 24'h000020, {12'd16, 12'd30}, st);
        end
        chk("mode_pwm_acc_before", pwm_accumulate, 0);
        issue(1, 7'd110, 0, 24'd1000, 24'd329, 24'd2000, 24'd1328, {12'd3328, 12'd1329}, st);
        chk("mode_stall_cycles", st, 23);
        chk("mode_pwm_acc_after", pwm_accumulate, 1);
        drain("mode_drain");

        // Range error: 3000 + 400 = 3400 >= 3329, written truncated.
        chk("range_err_clear", range_err, 0);
        issue(1, 7'd9, 0, 24'd3000, 24'd400, 24'd1, 24'd2, {12'd3, 12'd3400}, st);
        drain("range_drain");
        chk("range_err_set", range_err, 1);
        issue(1, 7'd10, 0, 24'd5, 24'd6, 24'd7, 24'd8, {12'd15, 12'd11}, st);
        drain("range_clean_drain");
        chk("range_err_sticky", range_err, 1);

        // Zeroize with ten pairs in flight: nothing may be written afterwards.
        for (int i = 0; i < 10; i++) begin
            issue(1, AW'(20 + i), i == 9, MW'(i), 24'd1, 24'd2, 24'd3, 24'd0, st);
        end
        zeroize = 1'b1;
        #1;
        chk("zero_in_ready", in_ready, 0);
        chk("zero_busy_before", busy, 1);
        q.delete();
        r0_sched.delete();
        r1_sched.delete();
        @(negedge clk);
        zeroize = 1'b0;
        chk("zero_busy_after", busy, 0);
        chk("zero_range_err", range_err, 0);
        chk("zero_pwm_acc", pwm_accumulate, 0);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-stream, then a fresh pair.
        for (int i = 0; i < 5; i++) begin
            issue(1, AW'(40 + i), 0, 24'd1, 24'd1, 24'd1, 24'd1, 24'd0, st);
        end
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {wr_en, wr_addr, wr_data, range_err, busy, done, in_ready, pwm_accumulate}, 0);
        q.delete();
        r0_sched.delete();
        r1_sched.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_busy_idle", busy, 0);
        issue(1, 7'd77, 1, 24'd100, 24'd200, 24'd300, 24'd400, {12'd700, 12'd300}, st);
        chk("rst_fresh_no_stall", st, 0);
        drain("rst_fresh_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
